// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: lets all threads of the compute core share one single-port
// data memory. Requests are granted one at a time in round-robin order. Each
// granted access is driven to memory for one cycle. A load then waits
// MEM_LATENCY cycles for read data. The response (load data, or a zero-data
// store acknowledge) goes back to the granted thread for one cycle.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   i_req_valid/write   per-thread request valid and type (1 = store)
//   i_req_addr/wdata    per-thread address / store data, thread i at slot i
//   o_req_ready         one-hot accept strobe, only ever high in IDLE
//   o_resp_valid        one-hot response strobe to the granted thread
//   o_resp_rdata        load data (zero for a store acknowledge)
//   o_grant_id          thread currently owning the memory
//   o_mem_*             memory access strobe, write enable, address, write data
//   i_mem_rdata         memory read data, valid MEM_LATENCY cycles after issue
//   o_busy              high whenever an access is in flight
module data_mem_arbiter #(
  parameter int NUM_THREADS     = 4,
  parameter int THREAD_ID_WIDTH = 2,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 16,
  parameter int MEM_LATENCY     = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_THREADS-1:0]            i_req_valid,
  input  logic [NUM_THREADS-1:0]            i_req_write,
  input  logic [NUM_THREADS*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_THREADS*DATA_WIDTH-1:0] i_req_wdata,
  output logic [NUM_THREADS-1:0]            o_req_ready,
  output logic [NUM_THREADS-1:0]            o_resp_valid,
  output logic [DATA_WIDTH-1:0]             o_resp_rdata,
  output logic [THREAD_ID_WIDTH-1:0]        o_grant_id,
  output logic                              o_mem_en,
  output logic                              o_mem_we,
  output logic [ADDR_WIDTH-1:0]             o_mem_addr,
  output logic [DATA_WIDTH-1:0]             o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]             i_mem_rdata,
  output logic                              o_busy
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
  localparam logic [NUM_THREADS-1:0] ONE_HOT0 = {{(NUM_THREADS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [THREAD_ID_WIDTH-1:0] r_last_grant;
  logic [THREAD_ID_WIDTH-1:0] r_grant_id;
  logic                       r_write;
  logic                       r_mem_en;
  logic                       r_mem_we;
  logic [ADDR_WIDTH-1:0]      r_mem_addr;
  logic [DATA_WIDTH-1:0]      r_mem_wdata;
  logic [NUM_THREADS-1:0]     r_resp_valid;
  logic [DATA_WIDTH-1:0]      r_resp_rdata;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_busy;

  logic                       w_found;
  logic [THREAD_ID_WIDTH-1:0] w_winner;
  logic [THREAD_ID_WIDTH-1:0] w_idx;
  logic [NUM_THREADS-1:0]     w_req_ready;
  logic [ADDR_WIDTH-1:0]      w_sel_addr;
  logic [DATA_WIDTH-1:0]      w_sel_wdata;

  assign w_sel_addr  = i_req_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = i_req_wdata[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];

  // Round-robin search: first valid thread after the last grant, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = {THREAD_ID_WIDTH{1'b0}};
    w_idx    = {THREAD_ID_WIDTH{1'b0}};
    for (int k = 1; k <= NUM_THREADS; k++) begin
      w_idx = THREAD_ID_WIDTH'((int'(r_last_grant) + k) % NUM_THREADS);
      if (i_req_valid[w_idx] && !w_found) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end else begin
        w_winner = w_winner;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and the combinational accept strobe.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = {NUM_THREADS{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_next = S_ISSUE;
          w_req_ready  = ONE_HOT0 << w_winner;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_write) begin
          w_state_next = S_RESP;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_RESP;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Accept strobe is masked while reset is held so it reads zero in reset.
  assign o_req_ready = reset ? {NUM_THREADS{1'b0}} : w_req_ready;

  // Request latch, memory drive, latency counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= THREAD_ID_WIDTH'(NUM_THREADS - 1);
      r_grant_id   <= {THREAD_ID_WIDTH{1'b0}};
      r_write      <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= {ADDR_WIDTH{1'b0}};
      r_mem_wdata  <= {DATA_WIDTH{1'b0}};
      r_resp_valid <= {NUM_THREADS{1'b0}};
      r_resp_rdata <= {DATA_WIDTH{1'b0}};
      r_cnt        <= {CNT_W{1'b0}};
      r_busy       <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_resp_valid <= {NUM_THREADS{1'b0}};
          if (w_found) begin
            // mem_en/mem_we are set here so they are high exactly in ISSUE.
            r_mem_addr   <= w_sel_addr;
            r_mem_wdata  <= w_sel_wdata;
            r_write      <= i_req_write[w_winner];
            r_last_grant <= w_winner;
            r_grant_id   <= w_winner;
            r_mem_en     <= 1'b1;
            r_mem_we     <= i_req_write[w_winner];
          end else begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
          end
        end
        S_ISSUE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_write) begin
            r_resp_rdata <= {DATA_WIDTH{1'b0}};
            r_resp_valid <= ONE_HOT0 << r_grant_id;
          end else begin
            r_cnt <= CNT_W'(MEM_LATENCY);
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_resp_rdata <= i_mem_rdata;
            r_resp_valid <= ONE_HOT0 << r_grant_id;
          end else begin
            r_resp_valid <= {NUM_THREADS{1'b0}};
          end
        end
        S_RESP: begin
          r_resp_valid <= {NUM_THREADS{1'b0}};
        end
        default: begin
          r_resp_valid <= {NUM_THREADS{1'b0}};
          r_mem_en     <= 1'b0;
          r_mem_we     <= 1'b0;
        end
      endcase
    end
  end

  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_grant_id   = r_grant_id;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: randomized requests against a transaction
// level reference model (round-robin pointer, busy-until cycle, reference
// memory). Expected responses go into a scoreboard queue; a monitor pops and
// compares whenever resp_valid is seen. A second instance built with
// MEM_LATENCY = 1 gets a directed single-load latency check.
module tb_data_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int L  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- main DUT (MEM_LATENCY = 2) ----------------
  logic [N-1:0]    v, w;
  logic [AW-1:0]   a [N];
  logic [DW-1:0]   d [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready, resp_valid;
  logic [DW-1:0]   resp_rdata, mem_wdata, mem_rdata;
  logic [1:0]      grant_id;
  logic            mem_en, mem_we, busy;
  logic [AW-1:0]   mem_addr;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int t = 0; t < N; t++) begin
      req_addr[t*AW +: AW]  = a[t];
      req_wdata[t*DW +: DW] = d[t];
    end
  end

  data_mem_arbiter #(.NUM_THREADS(N), .THREAD_ID_WIDTH(2), .ADDR_WIDTH(AW),
                     .DATA_WIDTH(DW), .MEM_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(v), .i_req_write(w), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_req_ready(req_ready), .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
    .o_grant_id(grant_id), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .o_busy(busy));

  // memory array with L-cycle read pipeline; junk outside the valid window
  logic [DW-1:0] dmem [256];
  logic [L-1:0]  pv;
  logic [DW-1:0] pd [L];
  logic [DW-1:0] junk;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
    end else begin
      junk <= DW'($urandom);
      if (mem_en && mem_we) dmem[mem_addr] <= mem_wdata;
      pv[0] <= mem_en && !mem_we;
      pd[0] <= dmem[mem_addr];
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign mem_rdata = pv[L-1] ? pd[L-1] : junk;

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int t; logic [DW-1:0] d; int due; } exp_t;
  exp_t sb[$];
  logic [DW-1:0] ref_mem [256];
  int   next_free = 0, last_g = N - 1, exp_gid = 0, iss_cyc = -1;
  logic          iss_we;
  logic [AW-1:0] iss_a;
  logic [DW-1:0] iss_d;
  logic [N-1:0]  acc_mask = '0;

  always @(negedge clk) begin
    logic [N-1:0] er;
    int   g, t;
    bit   idle;
    exp_t e;
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      next_free = 0; last_g = N - 1; exp_gid = 0; iss_cyc = -1;
      sb.delete();
      acc_mask = '0;
    end else begin
      er   = '0;
      g    = -1;
      idle = (cyc >= next_free);
      chk("busy", busy, !idle);
      chk("grant_id", grant_id, exp_gid);
      if (cyc == iss_cyc) begin
        chk("mem_en", mem_en, 1);
        chk("mem_we", mem_we, iss_we);
        chk("mem_addr", mem_addr, iss_a);
        chk("mem_wdata", mem_wdata, iss_d);
      end else begin
        chk("mem_en_idle", mem_en, 0);
        chk("mem_we_idle", mem_we, 0);
      end
      if (idle) begin
        for (int k = 1; k <= N; k++) begin
          t = (last_g + k) % N;
          if (g < 0 && v[t]) g = t;
        end
      end
      if (g >= 0) begin
        er[g]   = 1'b1;
        last_g  = g;
        exp_gid = g;
        iss_cyc = cyc + 1;
        iss_we  = w[g];
        iss_a   = a[g];
        iss_d   = d[g];
        e.t     = g;
        if (w[g]) begin
          e.d = '0;
          e.due = cyc + 2;
          next_free = cyc + 3;
          ref_mem[a[g]] = d[g];
        end else begin
          e.d = ref_mem[a[g]];
          e.due = cyc + 2 + L;
          next_free = cyc + 3 + L;
        end
        sb.push_back(e);
      end
      chk("req_ready", req_ready, er);
      acc_mask = er;
    end
  end

  // response monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (sb.size() > 0 && sb[0].due < cyc) begin
        chk("resp_timeout", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (resp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", resp_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("resp_valid", resp_valid, 32'd1 << e.t);
          chk("resp_rdata", resp_rdata, e.d);
          chk("resp_cycle", cyc, e.due);
        end
      end
    end
  end

  // ---------------- second DUT (MEM_LATENCY = 1) ----------------
  logic [N-1:0]    v1, rdy1, rv1_out;
  logic [N*AW-1:0] addr1;
  logic [DW-1:0]   rdata1, wdata1, mrd1, rd1;
  logic [1:0]      gid1;
  logic            en1, we1, busy1, rv1;
  logic [AW-1:0]   maddr1;

  data_mem_arbiter #(.NUM_THREADS(N), .THREAD_ID_WIDTH(2), .ADDR_WIDTH(AW),
                     .DATA_WIDTH(DW), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .i_req_valid(v1), .i_req_write(4'b0000), .i_req_addr(addr1), .i_req_wdata({N*DW{1'b0}}),
    .o_req_ready(rdy1), .o_resp_valid(rv1_out), .o_resp_rdata(rdata1),
    .o_grant_id(gid1), .o_mem_en(en1), .o_mem_we(we1),
    .o_mem_addr(maddr1), .o_mem_wdata(wdata1), .i_mem_rdata(mrd1),
    .o_busy(busy1));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rv1 <= 1'b0;
    end else begin
      rv1 <= en1 && !we1;
      rd1 <= {8'hC3, maddr1};
    end
  end
  assign mrd1 = rv1 ? rd1 : 16'hDEAD;

  // ---------------- stimulus ----------------
  task automatic newreq(input int t, input bit wr);
    v[t] = 1'b1;
    w[t] = wr;
    a[t] = AW'($urandom_range(0, 15));
    d[t] = DW'($urandom);
  endtask

  // mode 0: hold only, 1: random requests/drops, 2: all threads keep loading
  task automatic step(input int mode);
    @(posedge clk);
    #1;
    for (int t = 0; t < N; t++) if (acc_mask[t]) v[t] = 1'b0;
    for (int t = 0; t < N; t++) begin
      if (mode == 2 && !v[t]) newreq(t, 1'b0);
      else if (mode == 1 && !v[t] && $urandom_range(0, 2) == 0) newreq(t, 1'(($urandom_range(0, 1))));
      else if (mode == 1 && v[t] && $urandom_range(0, 19) == 0) v[t] = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_accept(input int t, input string nm);
    for (int i = 0; i < 20 && v[t]; i++) step(0);
    chk(nm, v[t], 0);
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = DW'($urandom);
      ref_mem[i] = dmem[i];
    end
    dmem[8'h10] = 16'hBEEF;
    ref_mem[8'h10] = 16'hBEEF;
    v = '0; w = '0; v1 = '0; addr1 = '0;
    for (int t = 0; t < N; t++) begin a[t] = '0; d[t] = '0; end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step(0); step(0);

    // thread 2 load from 0x10
    v[2] = 1'b1; w[2] = 1'b0; a[2] = 8'h10; d[2] = 16'h5A5A;
    wait_accept(2, "accept_t2_load");
    repeat (8) step(0);
    // thread 1 store 0x1234 to 0x20
    v[1] = 1'b1; w[1] = 1'b1; a[1] = 8'h20; d[1] = 16'h1234;
    wait_accept(1, "accept_t1_store");
    repeat (6) step(0);

    // all threads loading continuously from reset
    v = '0;
    pulse_reset();
    repeat (40) step(2);
    repeat (30) step(0);

    // randomized traffic
    repeat (1500) step(1);
    repeat (40) step(0);

    // reset pulse while a thread-0 load is in WAIT
    v[0] = 1'b1; w[0] = 1'b0; a[0] = 8'h05; d[0] = 16'h0;
    wait_accept(0, "accept_t0_pre_reset");
    step(0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    newreq(0, 1'b0);
    newreq(3, 1'b0);
    wait_accept(0, "accept_t0_after_reset");
    wait_accept(3, "accept_t3_after_reset");
    repeat (10) step(0);
    chk("sb_drained", sb.size(), 0);

    // MEM_LATENCY = 1 single load
    @(posedge clk);
    #1;
    v1 = 4'b0001;
    addr1[AW-1:0] = 8'h33;
    acc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy1 != '0) begin
        acc = cyc;
        break;
      end
    end
    chk("l1_req_ready", rdy1, 4'b0001);
    @(posedge clk);
    #1 v1 = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv1_out != '0) break;
    end
    chk("l1_resp_valid", rv1_out, 4'b0001);
    chk("l1_latency", cyc - acc, 3);
    chk("l1_rdata", rdata1, 16'hC333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
